// File: rtl/waxwing_pkg.sv
// Shared constants for the waxwing core: opcode map, FSM states, flag bits
// and the architectural register indices.
package waxwing_pkg;

    localparam logic [7:0] I_NOP = 8'h00;
    localparam logic [7:0] I_ADD = 8'h01;
    localparam logic [7:0] I_ADC = 8'h02;
    localparam logic [7:0] I_SUB = 8'h03;
    localparam logic [7:0] I_SBC = 8'h04;
    localparam logic [7:0] I_CMP = 8'h05;
    localparam logic [7:0] I_MUL = 8'h06;
    localparam logic [7:0] I_DIV = 8'h07;
    localparam logic [7:0] I_AND = 8'h08;
    localparam logic [7:0] I_OR  = 8'h09;
    localparam logic [7:0] I_XOR = 8'h0A;
    localparam logic [7:0] I_NOR = 8'h0B;
    localparam logic [7:0] I_LSL = 8'h0C;
    localparam logic [7:0] I_LSR = 8'h0D;
    localparam logic [7:0] I_MOV = 8'h0E;
    localparam logic [7:0] I_JMP = 8'h0F;
    localparam logic [7:0] I_JZ  = 8'h10;
    localparam logic [7:0] I_JNZ = 8'h11;
    localparam logic [7:0] I_JL  = 8'h12;
    localparam logic [7:0] I_JGE = 8'h13;
    localparam logic [7:0] I_LDB = 8'h14;
    localparam logic [7:0] I_LDW = 8'h15;
    localparam logic [7:0] I_STB = 8'h16;
    localparam logic [7:0] I_STW = 8'h17;
    localparam logic [7:0] I_DIE = 8'h18;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, HALT} state_e;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    localparam int REG_SP = 11;
    localparam int REG_BA = 12;
    localparam int REG_FL = 13;

    function automatic logic is_mem_op(input logic [7:0] op);
        return (op == I_LDB) || (op == I_LDW) || (op == I_STB) || (op == I_STW);
    endfunction

endpackage

// File: rtl/waxwing_alu.sv
// Combinational ALU: arithmetic with carry/overflow, multiply, unsigned
// divide, bitwise logic and shifts. The core decides which flags to keep.
module waxwing_alu import waxwing_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic [7:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] result,
    output logic              n,
    output logic              z,
    output logic              v,
    output logic              c
);
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W:0]   ax, bx, cx;
    logic [SH_W-1:0]   shamt;

    assign ax    = {1'b0, a};
    assign bx    = {1'b0, b};
    assign cx    = (op == I_ADC || op == I_SBC) ? {{DATA_W{1'b0}}, cin} : '0;
    assign shamt = b[SH_W-1:0];

    // NOTE: every output gets a default first so this block cannot infer a latch.
    always_comb begin
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            I_ADD, I_ADC: begin
                {c, result} = ax + bx + cx;
                v = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            I_SUB, I_SBC, I_CMP: begin
                // The extra top bit of the difference is the borrow.
                {c, result} = ax - bx - cx;
                v = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            I_MUL: result = a * b;
            I_DIV: begin
                if (b == '0) begin
                    result = '1;
                    v      = 1'b1;
                end else begin
                    result = a / b;
                end
            end
            I_AND: result = a & b;
            I_OR:  result = a | b;
            I_XOR: result = a ^ b;
            I_NOR: result = ~(a | b);
            I_LSL: {c, result} = ax << shamt;
            I_LSR: {result, c} = {a, 1'b0} >> shamt;
            I_MOV: result = b;
            default: result = '0;
        endcase
        n = result[DATA_W-1];
        z = (result == '0);
    end

endmodule

// File: rtl/waxwing_core.sv
// Parametrised multi-cycle core: 8-byte instruction fetch over a req/ack byte
// port, decode, execute, byte/word load-store and halt with debug readout.
module waxwing_core import waxwing_pkg::*; #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 16,
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [7:0]              mem_wdata,
    input  logic [7:0]              mem_rdata,
    input  logic                    mem_ack,
    output logic                    halted,
    input  logic [$clog2(NREG)-1:0] dbg_sel,
    output logic [DATA_W-1:0]       dbg_data
);
    localparam int RW = $clog2(NREG);
    localparam int NB = DATA_W / 8;
    localparam logic [RW-1:0] FL_IDX = RW'(REG_FL);
    localparam logic [RW-1:0] BA_IDX = RW'(REG_BA);

    state_e              state;
    logic [ADDR_W-1:0]   pc, jmp, ea;
    logic [2:0]          cnt;
    logic [63:0]         ibuf;
    logic [DATA_W-1:0]   regs [NREG];
    logic [DATA_W-1:0]   opr0, opr1, opr2, shadow;

    logic [7:0]          opcode, mode;
    logic [RW-1:0]       reg0, reg1;
    logic [63:0]         raw_wide;
    logic [DATA_W-1:0]   raw2, opr2_d, alu_res, fl_word, ld_word;
    logic [3:0]          flags, fl_new;
    logic                alu_n, alu_z, alu_v, alu_c;
    logic                wr_en, fl_en, take, is_store, mem_last;
    logic                unused_bits;

    assign opcode   = ibuf[7:0];
    assign mode     = ibuf[15:8];
    assign reg0     = ibuf[16 +: RW];
    assign reg1     = ibuf[24 +: RW];
    assign raw_wide = {32'b0, ibuf[63:32]};
    assign raw2     = raw_wide[DATA_W-1:0];
    assign opr2_d   = mode[0] ? regs[raw2[RW-1:0]] : raw2;
    assign flags    = regs[FL_IDX][3:0];
    assign dbg_data = regs[dbg_sel];
    assign unused_bits = ^{ibuf, raw_wide};

    assign is_store = (opcode == I_STB) || (opcode == I_STW);
    assign mem_last = (opcode == I_LDB) || (opcode == I_STB) || (cnt == 3'(NB - 1));
    assign ld_word  = shadow | (DATA_W'(mem_rdata) << {cnt, 3'b000});

    waxwing_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (opcode),
        .a      ((opcode == I_CMP) ? opr0 : opr1),
        .b      (opr2),
        .cin    (flags[FLAG_C]),
        .result (alu_res),
        .n      (alu_n),
        .z      (alu_z),
        .v      (alu_v),
        .c      (alu_c)
    );

    always_comb begin
        wr_en  = 1'b0;
        fl_en  = 1'b0;
        take   = 1'b0;
        fl_new = flags;
        case (opcode)
            I_ADD, I_ADC, I_SUB, I_SBC, I_MUL, I_DIV, I_LSL, I_LSR, I_CMP: begin
                wr_en = (opcode != I_CMP);
                fl_en = 1'b1;
                fl_new[FLAG_N] = alu_n;
                fl_new[FLAG_Z] = alu_z;
                fl_new[FLAG_C] = alu_c;
                if (opcode != I_LSL && opcode != I_LSR) fl_new[FLAG_V] = alu_v;
            end
            I_AND, I_OR, I_XOR, I_NOR: begin
                wr_en = 1'b1;
                fl_en = 1'b1;
                fl_new[FLAG_N] = alu_n;
                fl_new[FLAG_Z] = alu_z;
            end
            I_MOV: wr_en = 1'b1;
            I_JMP: take = 1'b1;
            I_JZ:  take = flags[FLAG_Z];
            I_JNZ: take = !flags[FLAG_Z];
            I_JL:  take = flags[FLAG_C];
            I_JGE: take = !flags[FLAG_C];
            default: ;
        endcase
        // Data lands in FL first, then the flag bits overwrite it.
        fl_word      = (wr_en && reg0 == FL_IDX) ? alu_res : regs[FL_IDX];
        fl_word[3:0] = fl_new;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // read in this block sees the value from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= ADDR_W'(RESET_PC);
            cnt       <= '0;
            ibuf      <= '0;
            opr0      <= '0;
            opr1      <= '0;
            opr2      <= '0;
            shadow    <= '0;
            jmp       <= '0;
            ea        <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
            // NOTE: the register file must clear on reset, so it is built
            // from flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (en) begin
            case (state)
                FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        ibuf[{cnt, 3'b000} +: 8] <= mem_rdata;
                        pc  <= pc + ADDR_W'(1);
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            mem_req <= 1'b0;
                            state   <= DECODE;
                        end else begin
                            mem_addr <= pc + ADDR_W'(1);
                        end
                    end
                end
                DECODE: begin
                    opr0  <= regs[reg0];
                    opr1  <= regs[reg1];
                    opr2  <= opr2_d;
                    jmp   <= mode[1] ? ADDR_W'(raw2) : ADDR_W'(regs[BA_IDX] + raw2);
                    ea    <= ADDR_W'(regs[reg1] + opr2_d);
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    if (wr_en) regs[reg0] <= alu_res;
                    if (fl_en) regs[FL_IDX] <= fl_word;
                    if (take) pc <= jmp;
                    if (is_mem_op(opcode)) begin
                        cnt    <= '0;
                        shadow <= '0;
                        state  <= MEM;
                    end else if (opcode == I_DIE) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        state <= FETCH;
                    end
                end
                MEM: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= ea;
                        mem_wdata <= opr0[7:0];
                    end else if (mem_ack) begin
                        shadow <= ld_word;
                        if (mem_last) begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            cnt     <= '0;
                            if (!is_store) regs[reg0] <= ld_word;
                            state   <= FETCH;
                        end else begin
                            cnt       <= cnt + 3'd1;
                            mem_addr  <= mem_addr + ADDR_W'(1);
                            mem_wdata <= 8'(opr0 >> {cnt + 3'd1, 3'b000});
                        end
                    end
                end
                HALT:    halted <= 1'b1;
                default: state <= FETCH;
            endcase
        end
    end

endmodule
